router_input_ctrl: RTL and testbench

//  Per-input-port header decoder / output requester for the NxN serial router; successor to the fixed 16-port FSM.

---
 rtl/router_input_ctrl_if.sv | 58 +++++
 rtl/router_input_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_router_input_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/router_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// router_input_ctrl_if
//   Groups the pin-side and arbiter-side signals of one router input-port
//   controller into a single bundle.
//
//   Parameters
//     NUM_PORTS  number of router output ports (power of 2, >= 2)
//
//   Signals
//     din              serial header/payload bit from the input pin
//     frame_n          active-low frame; rises together with the last payload bit
//     grant_in         per-output grants from the output arbiters
//     request_out      one-hot request to the addressed output arbiter
//     address_out      captured destination address
//     data_enable_out  din carries a valid payload bit this cycle
//     busy_out         controller is not idle
//     drop_out         one-cycle pulse when a packet is discarded on grant timeout
//
//   Modports
//     master  the input controller (consumes pins/grants, drives requests)
//     slave   the surroundings: input pins plus output arbiters
// -----------------------------------------------------------------------------
interface router_input_ctrl_if #(
  parameter int NUM_PORTS = 16
);
  localparam int ADDR_W = $clog2(NUM_PORTS);

  logic                 din;
  logic                 frame_n;
  logic [NUM_PORTS-1:0] grant_in;
  logic [NUM_PORTS-1:0] request_out;
  logic [ADDR_W-1:0]    address_out;
  logic                 data_enable_out;
  logic                 busy_out;
  logic                 drop_out;

  modport master (
    input  din,
    input  frame_n,
    input  grant_in,
    output request_out,
    output address_out,
    output data_enable_out,
    output busy_out,
    output drop_out
  );

  modport slave (
    output din,
    output frame_n,
    output grant_in,
    input  request_out,
    input  address_out,
    input  data_enable_out,
    input  busy_out,
    input  drop_out
  );
endinterface : router_input_ctrl_if

// File: rtl/router_input_ctrl.sv
// -----------------------------------------------------------------------------
// router_input_ctrl
//   Per-input-port header decoder and output requester for the NxN serial
//   router. One instance sits between each input port's pins and the
//   per-output arbiters.
//
//   After frame_n falls, the destination address is shifted in MSB first from
//   din (ADDR_W cycles including the cycle frame_n is first seen low). The
//   controller then raises a one-hot request towards the addressed output and
//   waits in a padding phase for at least PAD_MIN cycles and for that output's
//   grant. Once both hold, every following cycle is flagged as payload through
//   data_enable_out until the cycle frame_n is seen high again.
//
//   Optional feature (compile-time macro ROUTER_GRANT_TIMEOUT_EN):
//     When defined, a packet that waits GRANT_TIMEOUT padding cycles without a
//     grant is dropped: the request is withdrawn, drop_out pulses once and the
//     rest of the frame is swallowed. When undefined the controller waits for
//     its grant indefinitely and drop_out is tied low.
//
//   Parameters
//     NUM_PORTS      number of output ports (power of 2, >= 2)
//     PAD_MIN        minimum number of padding cycles before payload (>= 1)
//     GRANT_TIMEOUT  padding cycles without grant before drop (> PAD_MIN)
//     ADDR_W         header address width, derived from NUM_PORTS
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    router_input_ctrl_if.master: din, frame_n, grant_in in;
//            request_out, address_out, data_enable_out, busy_out, drop_out out
//
//   Every output is a register or a decode of registered state; no input
//   reaches an output combinationally.
// -----------------------------------------------------------------------------
module router_input_ctrl #(
  parameter  int NUM_PORTS     = 16,
  parameter  int PAD_MIN       = 1,
  parameter  int GRANT_TIMEOUT = 64,
  localparam int ADDR_W        = $clog2(NUM_PORTS)
) (
  input  logic                clk,
  input  logic                reset,
  router_input_ctrl_if.master bus
);

  // Padding counter is wide enough for the larger of the two thresholds.
  localparam int PAD_LIMIT = (PAD_MIN > GRANT_TIMEOUT) ? PAD_MIN : GRANT_TIMEOUT;
  localparam int PAD_W     = $clog2(PAD_LIMIT + 1);
  localparam int BIT_W     = $clog2(ADDR_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_PAD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] shift_q;        // header bits received so far
  logic [BIT_W-1:0]  bit_cnt_q;      // header bits received, valid in ADDR
  logic [ADDR_W-1:0] addr_q;         // destination, valid from PAD entry
  logic [PAD_W-1:0]  pad_cnt_q;      // current PAD cycle number, 1-based
  logic              frame_armed_q;  // frame_n seen high since reset

  logic [ADDR_W-1:0] hdr_word;       // header including this cycle's din bit
  logic              grant_hit;
  logic              pad_min_met;

  // ---------------------------------------------------------------------------
  // Header assembly and PAD exit conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    // In IDLE the incoming bit is the MSB; in ADDR it is appended below the
    // bits already collected. The width cast drops nothing that matters
    // because at most ADDR_W bits are ever collected.
    if (state_q == ST_ADDR) begin
      hdr_word = ADDR_W'({shift_q, bus.din});
    end else begin
      hdr_word = ADDR_W'(bus.din);
    end
  end

  // Only the grant for our own output counts; the others belong to other
  // input controllers competing for different outputs.
  assign grant_hit   = bus.grant_in[addr_q];
  assign pad_min_met = (pad_cnt_q >= PAD_W'(PAD_MIN));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments so every register in the
  // design samples the values that existed before this clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting state_d before the case means no branch can leave it
    // unassigned, so no latch is inferred.
    state_d = state_q;

    unique case (state_q)
      ST_IDLE: begin
        // A frame left low across a reset is not a new frame: wait until
        // frame_n has been seen high at least once.
        if (!bus.frame_n && frame_armed_q) begin
          state_d = (ADDR_W == 1) ? ST_PAD : ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bus.frame_n) begin
          state_d = ST_IDLE;                      // frame aborted in header
        end else if (bit_cnt_q == BIT_W'(ADDR_W - 1)) begin
          state_d = ST_PAD;                       // this cycle holds the LSB
        end
      end

      ST_PAD: begin
        if (bus.frame_n) begin
          state_d = ST_IDLE;                      // frame aborted while waiting
        end else if (grant_hit && pad_min_met) begin
          state_d = ST_PAYLOAD;                   // grant wins over timeout
        end
`ifdef ROUTER_GRANT_TIMEOUT_EN
        else if (pad_cnt_q >= PAD_W'(GRANT_TIMEOUT)) begin
          state_d = ST_DROP;
        end
`endif
      end

      ST_PAYLOAD: begin
        // The bit sampled with frame_n high is still payload; we leave after it.
        if (bus.frame_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (bus.frame_n) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      addr_q        <= '0;
      pad_cnt_q     <= '0;
      frame_armed_q <= 1'b0;
    end else begin
      // Every frame ends with frame_n sampled high, so once armed this stays
      // set until the next reset.
      frame_armed_q <= frame_armed_q | bus.frame_n;

      if (state_q == ST_IDLE || state_q == ST_ADDR) begin
        shift_q <= hdr_word;
      end

      if (state_d == ST_ADDR) begin
        bit_cnt_q <= (state_q == ST_ADDR) ? bit_cnt_q + BIT_W'(1) : BIT_W'(1);
      end else begin
        bit_cnt_q <= '0;
      end

      // Address is published on PAD entry and cleared whenever we go idle.
      if (state_d == ST_IDLE) begin
        addr_q <= '0;
      end else if (state_d == ST_PAD && state_q != ST_PAD) begin
        addr_q <= hdr_word;
      end

      // Counts 1, 2, 3 ... across PAD cycles and saturates instead of wrapping.
      if (state_d == ST_PAD) begin
        if (state_q != ST_PAD) begin
          pad_cnt_q <= PAD_W'(1);
        end else if (!(&pad_cnt_q)) begin
          pad_cnt_q <= pad_cnt_q + PAD_W'(1);
        end
      end else begin
        pad_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop pulse
  // ---------------------------------------------------------------------------
`ifdef ROUTER_GRANT_TIMEOUT_EN
  logic drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= (state_q == ST_PAD) && (state_d == ST_DROP);
    end
  end

  assign bus.drop_out = drop_q;
`else
  assign bus.drop_out = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state
  // ---------------------------------------------------------------------------
  // The request is held through PAYLOAD even if the grant drops; the arbiter
  // decides how long a grant persists.
  assign bus.request_out     = (state_q == ST_PAD || state_q == ST_PAYLOAD)
                               ? (NUM_PORTS'(1) << addr_q) : '0;
  assign bus.address_out     = addr_q;
  assign bus.data_enable_out = (state_q == ST_PAYLOAD);
  assign bus.busy_out        = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_request_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.request_out));

  a_enable_has_request : assert property (@(posedge clk) disable iff (reset)
    bus.data_enable_out |-> (bus.request_out != '0));

endmodule : router_input_ctrl

// File: tb/tb_router_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_input_ctrl
//   Two controllers share one clock: unit 0 with PAD_MIN=1, unit 1 with
//   PAD_MIN=5. Each packet is described by a few numbers (address, PAD cycle in
//   which the grant appears, payload length, abort/reset/drop point); from
//   those the reference model derives, with plain arithmetic, the cycle windows
//   in which busy, request, address, data enable and drop must be asserted.
//   Cycle t of a packet is the cycle in which frame_n is first driven low
//   plus t; outputs are compared on the falling edge before inputs change.
// -----------------------------------------------------------------------------
module tb_router_input_ctrl;

  localparam int NP  = 16;
  localparam int A   = 4;     // header length in cycles
  localparam int PM0 = 1;
  localparam int PM1 = 5;
  localparam int GT  = 64;

  // Packet kinds
  localparam int K_NORMAL  = 0;
  localparam int K_HDR_ABT = 1;  // frame_n high on header bit 'ab' (0-based)
  localparam int K_PAD_ABT = 2;  // frame_n high on PAD cycle 'ab' (1-based)
  localparam int K_RESET   = 3;  // reset on payload cycle 'ab' (0-based)
  localparam int K_DROP    = 4;  // no grant, frame_n high 'ab' cycles into DROP

  logic clk = 1'b0;
  logic reset0;
  logic reset1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  router_input_ctrl_if #(.NUM_PORTS(NP)) if0 ();
  router_input_ctrl_if #(.NUM_PORTS(NP)) if1 ();

  router_input_ctrl #(.NUM_PORTS(NP), .PAD_MIN(PM0), .GRANT_TIMEOUT(GT)) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (if0)
  );

  router_input_ctrl #(.NUM_PORTS(NP), .PAD_MIN(PM1), .GRANT_TIMEOUT(GT)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (if1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic r, input logic d, input logic f,
                       input logic [NP-1:0] g);
    if (u == 0) begin
      reset0 = r; if0.din = d; if0.frame_n = f; if0.grant_in = g;
    end else begin
      reset1 = r; if1.din = d; if1.frame_n = f; if1.grant_in = g;
    end
  endtask

  task automatic check_outputs(input int u, input int t, input logic busy,
                               input logic [NP-1:0] req, input logic [3:0] addr,
                               input logic de, input logic drop, input logic chk_addr);
    logic [NP-1:0] o_req;
    logic [3:0]    o_addr;
    logic          o_busy, o_de, o_drop;
    if (u == 0) begin
      o_req = if0.request_out; o_addr = if0.address_out; o_busy = if0.busy_out;
      o_de = if0.data_enable_out; o_drop = if0.drop_out;
    end else begin
      o_req = if1.request_out; o_addr = if1.address_out; o_busy = if1.busy_out;
      o_de = if1.data_enable_out; o_drop = if1.drop_out;
    end
    check($sformatf("u%0d t%0d busy", u, t), 32'(o_busy), 32'(busy));
    check($sformatf("u%0d t%0d request", u, t), 32'(o_req), 32'(req));
    check($sformatf("u%0d t%0d data_enable", u, t), 32'(o_de), 32'(de));
    check($sformatf("u%0d t%0d drop", u, t), 32'(o_drop), 32'(drop));
    if (chk_addr) check($sformatf("u%0d t%0d address", u, t), 32'(o_addr), 32'(addr));
  endtask

  // One packet on unit u followed by 'gap' idle cycles.
  //   gi : PAD cycle (1-based) from which grant_in[addr] is high
  task automatic run_pkt(input int u, input int addr, input int gi, input int len,
                         input int kind, input int ab, input int gap);
    int            pm, n_pad, pay_lo, pay_hi, req_hi, busy_hi, fr_hi, drop_t, rst_t, g_on, total;
    logic [3:0]    a4;
    logic [NP-1:0] onehot, noise;
    logic          post_rst, in_drop, gbit, e_win;

    a4     = 4'(addr);
    onehot = NP'(1) << a4;
    pm     = (u == 0) ? PM0 : PM1;
    n_pad  = (gi > pm) ? gi : pm;
    pay_lo = A + n_pad;
    pay_hi = pay_lo;
    drop_t = -1;
    rst_t  = -1;
    g_on   = A + gi - 1;

    case (kind)
      K_HDR_ABT: begin fr_hi = ab;     busy_hi = ab + 1; req_hi = A;       end
      K_PAD_ABT: begin fr_hi = A + ab - 1; busy_hi = A + ab; req_hi = busy_hi; end
      K_DROP: begin
        drop_t = A + GT; req_hi = drop_t; fr_hi = drop_t + ab; busy_hi = fr_hi + 1;
      end
      default: begin
        pay_hi = pay_lo + len; fr_hi = pay_hi - 1; busy_hi = pay_hi; req_hi = pay_hi;
      end
    endcase
    total = busy_hi + gap;
    if (kind == K_RESET) begin
      // Frame stays low a while after reset; the controller must ignore it.
      rst_t = pay_lo + ab;
      fr_hi = rst_t + 3;
      total = rst_t + 5 + gap;
    end

    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      post_rst = (rst_t >= 0) && (t > rst_t);
      in_drop  = (drop_t >= 0) && (t >= drop_t) && (t < busy_hi);
      e_win    = !post_rst && (t >= A) && (t < req_hi);
      check_outputs(u, t,
                    !post_rst && (t >= 1) && (t < busy_hi),
                    e_win ? onehot : '0,
                    e_win ? a4 : 4'd0,
                    !post_rst && (t >= pay_lo) && (t < pay_hi),
                    (t == drop_t),
                    !in_drop);

      noise = NP'($urandom) & ~onehot;
      gbit  = 1'b0;
      if (t >= g_on && t < pay_lo && t < busy_hi) gbit = 1'b1;
      if (gi == 1 && t < g_on) gbit = 1'b1;                   // grant already up
      if (t >= pay_lo && t < pay_hi) gbit = 1'($urandom_range(0, 1));  // may fall
      drive(u, (t == rst_t),
            (t < A) ? a4[A - 1 - t] : 1'($urandom_range(0, 1)),
            (t < fr_hi) ? 1'b0 : 1'b1,
            noise | (gbit ? onehot : '0));
    end
  endtask

  initial begin
    int u, addr, gi, len, kind, ab, sel;

    reset0 = 1'b1; reset1 = 1'b1;
    if0.din = 1'b0; if0.frame_n = 1'b1; if0.grant_in = '0;
    if1.din = 1'b0; if1.frame_n = 1'b1; if1.grant_in = '0;
    repeat (2) @(negedge clk);
    check_outputs(0, 0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_outputs(1, 0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b1);
    reset0 = 1'b0; reset1 = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios
    run_pkt(0, 11, 1, 6, K_NORMAL, 0, 0);     // header 1011, grant already high
    run_pkt(1, 6, 1, 8, K_NORMAL, 0, 1);      // PAD_MIN=5, 8-bit payload
    run_pkt(0, 3, 21, 5, K_NORMAL, 0, 0);     // grant withheld 20 PAD cycles
    run_pkt(0, 9, 3, 4, K_HDR_ABT, 2, 0);     // abort on 3rd header bit
    run_pkt(1, 12, 2, 8, K_RESET, 3, 0);      // reset in payload
    run_pkt(1, 5, 1, 3, K_NORMAL, 0, 0);      // fresh packet after reset
`ifdef ROUTER_GRANT_TIMEOUT_EN
    run_pkt(0, 13, 1000, 0, K_DROP, 3, 1);    // no grant: drop after 64 PAD cycles
`else
    run_pkt(0, 13, 1000, 0, K_PAD_ABT, 70, 1); // no grant: waits, never drops
`endif

    // Randomised packets, frequently back-to-back
    for (int n = 0; n < 60; n++) begin
      u    = $urandom_range(0, 1);
      addr = $urandom_range(0, NP - 1);
      gi   = $urandom_range(1, 9);
      len  = $urandom_range(1, 10);
      ab   = 0;
      sel  = $urandom_range(0, 9);
      if (sel <= 6) begin
        kind = K_NORMAL;
      end else if (sel == 7) begin
        kind = K_HDR_ABT; ab = $urandom_range(1, A - 1);
      end else if (sel == 8) begin
        kind = K_PAD_ABT; gi = $urandom_range(2, 9); ab = $urandom_range(1, gi - 1);
      end else begin
        kind = K_RESET; ab = $urandom_range(0, len - 1);
      end
      run_pkt(u, addr, gi, len, kind, ab, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_router_input_ctrl
